// File: rtl/sorter_arbiter.sv
// Two-requester front end for a shared batch sorter: grants one requester at a
// time, streams DEPTH elements into the sorter, then returns DEPTH sorted ones.
module sorter_arbiter #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 10,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] r0_data_i,
  input  logic             r0_valid_i,
  output logic             r0_ready_o,
  input  logic [WIDTH-1:0] r1_data_i,
  input  logic             r1_valid_i,
  output logic             r1_ready_o,
  output logic [WIDTH-1:0] r0_data_o,
  output logic             r0_valid_o,
  input  logic             r0_ready_i,
  output logic [WIDTH-1:0] r1_data_o,
  output logic             r1_valid_o,
  input  logic             r1_ready_i,
  output logic [WIDTH-1:0] srt_data_o,
  output logic             srt_valid_o,
  input  logic             srt_ready_i,
  input  logic [WIDTH-1:0] srt_data_i,
  input  logic             srt_valid_i,
  output logic             srt_ready_o,
  output logic             owner_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e        state_r, state_s;
  logic          owner_r, owner_s;
  logic          last_grant_r, last_grant_s;
  logic [CW-1:0] load_cnt_r, load_cnt_s;
  logic [CW-1:0] drain_cnt_r, drain_cnt_s;
  logic          err_r, err_s;
  logic          own_valid_s, own_ready_s;
  logic          load_xfer_s, drain_xfer_s;

  assign own_valid_s  = owner_r ? r1_valid_i : r0_valid_i;
  assign own_ready_s  = owner_r ? r1_ready_i : r0_ready_i;
  assign load_xfer_s  = (state_r == ST_LOAD) && own_valid_s && srt_ready_i;
  assign drain_xfer_s = (state_r == ST_DRAIN) && srt_valid_i && own_ready_s;

  // Handshake routing between the owner and the sorter; everything else idles at zero.
  always_comb begin
    r0_ready_o  = 1'b0;
    r1_ready_o  = 1'b0;
    r0_valid_o  = 1'b0;
    r1_valid_o  = 1'b0;
    r0_data_o   = '0;
    r1_data_o   = '0;
    srt_valid_o = 1'b0;
    srt_data_o  = '0;
    srt_ready_o = 1'b0;
    case (state_r)
      ST_LOAD: begin
        srt_valid_o = own_valid_s;
        srt_data_o  = owner_r ? r1_data_i : r0_data_i;
        if (owner_r) begin
          r1_ready_o = srt_ready_i;
        end else begin
          r0_ready_o = srt_ready_i;
        end
      end
      ST_DRAIN: begin
        srt_ready_o = own_ready_s;
        if (owner_r) begin
          r1_valid_o = srt_valid_i;
          r1_data_o  = srt_data_i;
        end else begin
          r0_valid_o = srt_valid_i;
          r0_data_o  = srt_data_i;
        end
      end
      default: begin
        srt_ready_o = 1'b0;
      end
    endcase
  end

  // Grant selection, batch counting and the sticky protocol-error flag.
  always_comb begin
    state_s      = state_r;
    owner_s      = owner_r;
    last_grant_s = last_grant_r;
    load_cnt_s   = load_cnt_r;
    drain_cnt_s  = drain_cnt_r;
    err_s        = err_r | (srt_valid_i && (state_r != ST_DRAIN));
    case (state_r)
      ST_IDLE: begin
        if (r0_valid_i && r1_valid_i) begin
          owner_s = ~last_grant_r;
          state_s = ST_LOAD;
        end else if (r0_valid_i) begin
          owner_s = 1'b0;
          state_s = ST_LOAD;
        end else if (r1_valid_i) begin
          owner_s = 1'b1;
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (load_xfer_s) begin
          if (load_cnt_r == CNT_LAST) begin
            load_cnt_s = '0;
            state_s    = ST_DRAIN;
          end else begin
            load_cnt_s = load_cnt_r + CW'(1);
          end
        end else begin
          load_cnt_s = load_cnt_r;
        end
      end
      ST_DRAIN: begin
        if (drain_xfer_s) begin
          if (drain_cnt_r == CNT_LAST) begin
            drain_cnt_s  = '0;
            last_grant_s = owner_r;
            state_s      = ST_IDLE;
          end else begin
            drain_cnt_s = drain_cnt_r + CW'(1);
          end
        end else begin
          drain_cnt_s = drain_cnt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Control registers; last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r      <= ST_IDLE;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      load_cnt_r   <= '0;
      drain_cnt_r  <= '0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      owner_r      <= owner_s;
      last_grant_r <= last_grant_s;
      load_cnt_r   <= load_cnt_s;
      drain_cnt_r  <= drain_cnt_s;
      err_r        <= err_s;
    end
  end

  assign owner_o = owner_r;
  assign busy_o  = (state_r != ST_IDLE);
  assign err_o   = err_r;

endmodule

// File: tb/tb_sorter_arbiter.sv
// Randomised bench for sorter_arbiter: requester sources/sinks plus a batch
// sorter model, checked against a round-robin and sort-order reference.
`timescale 1ns/1ps
module tb_sorter_arbiter;
  localparam int WIDTH      = 8;
  localparam int DEPTH      = 10;
  localparam int DEPTH_LOG2 = 4;

  typedef logic [WIDTH-1:0] elem_q_t[$];

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [WIDTH-1:0] r0_data_i, r1_data_i, r0_data_o, r1_data_o;
  logic             r0_valid_i, r1_valid_i, r0_ready_o, r1_ready_o;
  logic             r0_valid_o, r1_valid_o, r0_ready_i, r1_ready_i;
  logic [WIDTH-1:0] srt_data_o, srt_data_i;
  logic             srt_valid_o, srt_ready_i, srt_valid_i, srt_ready_o;
  logic             owner_o, busy_o, err_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  sorter_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .r0_data_i(r0_data_i), .r0_valid_i(r0_valid_i), .r0_ready_o(r0_ready_o),
    .r1_data_i(r1_data_i), .r1_valid_i(r1_valid_i), .r1_ready_o(r1_ready_o),
    .r0_data_o(r0_data_o), .r0_valid_o(r0_valid_o), .r0_ready_i(r0_ready_i),
    .r1_data_o(r1_data_o), .r1_valid_o(r1_valid_o), .r1_ready_i(r1_ready_i),
    .srt_data_o(srt_data_o), .srt_valid_o(srt_valid_o), .srt_ready_i(srt_ready_i),
    .srt_data_i(srt_data_i), .srt_valid_i(srt_valid_i), .srt_ready_o(srt_ready_o),
    .owner_o(owner_o), .busy_o(busy_o), .err_o(err_o)
  );

  // reference model state and batch plan
  bit      model_last_grant, model_err;
  bit      v0, v1;
  int      src_stall, srt_stall, dst_stall, hold_at, hold_len, err_at, winner;
  elem_q_t in_q, obs_load, obs_ret, exp_ret;
  // batch observations
  bit      got_owner_valid, owner_changed, nonowner_act, iso_viol, hold_viol, timeout;
  logic    got_owner, busy_after, err_after_inject;

  function automatic elem_q_t sorted_copy(elem_q_t q);
    elem_q_t s;
    foreach (q[i]) begin
      int p;
      p = 0;
      while (p < s.size() && s[p] <= q[i]) p++;
      s.insert(p, q[i]);
    end
    return s;
  endfunction

  task automatic plan(input bit a0, input bit a1, input int ss, input int ks, input int ds);
    v0 = a0; v1 = a1; src_stall = ss; srt_stall = ks; dst_stall = ds;
    hold_at = -1; hold_len = 0; err_at = -1;
    in_q = {};
    for (int i = 0; i < DEPTH; i++) in_q.push_back(WIDTH'($urandom));
  endtask

  task automatic clear_inputs();
    r0_valid_i = 1'b0; r1_valid_i = 1'b0; r0_data_i = '0; r1_data_i = '0;
    r0_ready_i = 1'b0; r1_ready_i = 1'b0;
    srt_valid_i = 1'b0; srt_ready_i = 1'b0; srt_data_i = '0;
  endtask

  // Runs one batch from IDLE: winner's source, sorter model, winner's sink.
  task automatic do_batch();
    int      load_n, ret_n, cyc, held, inj_cyc;
    bit      collecting, done, src_v, own_rdy, holding;
    elem_q_t srt_q;
    obs_load = {}; obs_ret = {};
    exp_ret = sorted_copy(in_q);
    if (v0 && v1) winner = model_last_grant ? 0 : 1;
    else          winner = v1 ? 1 : 0;
    got_owner_valid = 0; got_owner = 1'b0; owner_changed = 0; nonowner_act = 0;
    iso_viol = 0; hold_viol = 0; err_after_inject = 1'b0; busy_after = 1'b1;
    load_n = 0; ret_n = 0; cyc = 0; held = 0; inj_cyc = -1;
    collecting = 1; done = 0;
    while (!done && cyc < 3000) begin
      @(posedge clk_i); #1; cyc++;
      if (inj_cyc >= 0 && cyc == inj_cyc + 1) err_after_inject = err_o;
      if (ret_n == DEPTH) begin
        srt_valid_i = 1'b0; srt_ready_i = 1'b0; r0_ready_i = 1'b0; r1_ready_i = 1'b0;
        #1;
        busy_after = busy_o;
        done = 1;
      end else begin
        src_v   = (load_n < DEPTH) && (!busy_o || int'($urandom_range(99)) >= src_stall);
        holding = (hold_at >= 0) && (ret_n == hold_at) && (held < hold_len);
        own_rdy = !holding && (int'($urandom_range(99)) >= dst_stall);
        if (holding) held++;
        if (winner == 0) begin
          r0_valid_i = src_v; r0_data_i = (load_n < DEPTH) ? in_q[load_n] : WIDTH'($urandom);
          r1_valid_i = v1;    r1_data_i = WIDTH'($urandom);
          r0_ready_i = own_rdy; r1_ready_i = 1'b1;
        end else begin
          r1_valid_i = src_v; r1_data_i = (load_n < DEPTH) ? in_q[load_n] : WIDTH'($urandom);
          r0_valid_i = v0;    r0_data_i = WIDTH'($urandom);
          r1_ready_i = own_rdy; r0_ready_i = 1'b1;
        end
        if (collecting) begin
          srt_ready_i = int'($urandom_range(99)) >= srt_stall;
          srt_valid_i = (err_at >= 0) && (obs_load.size() == err_at) && (inj_cyc < 0);
          srt_data_i  = WIDTH'($urandom);
          if (srt_valid_i) inj_cyc = cyc;
        end else begin
          srt_ready_i = 1'b0;
          srt_valid_i = int'($urandom_range(99)) >= srt_stall;
          srt_data_i  = srt_q[ret_n];
        end
        #1;
        if (busy_o === 1'b1) begin
          if (!got_owner_valid) begin
            got_owner_valid = 1; got_owner = owner_o;
          end else if (owner_o !== got_owner) begin
            owner_changed = 1;
          end
        end
        if (holding && srt_ready_o !== 1'b0) hold_viol = 1;
        if (winner == 0) begin
          if ({r1_ready_o, r1_valid_o} !== 2'b00 || r1_data_o !== '0) nonowner_act = 1;
        end else begin
          if ({r0_ready_o, r0_valid_o} !== 2'b00 || r0_data_o !== '0) nonowner_act = 1;
        end
        if (collecting && ({r0_valid_o, r1_valid_o, srt_ready_o} !== 3'b000 ||
                           r0_data_o !== '0 || r1_data_o !== '0)) iso_viol = 1;
        if ((!collecting || busy_o !== 1'b1) &&
            ({srt_valid_o, r0_ready_o, r1_ready_o} !== 3'b000 || srt_data_o !== '0)) iso_viol = 1;
        if (!collecting && srt_valid_i && srt_ready_o === 1'b1) ret_n++;
        if (winner == 0 ? (r0_valid_o === 1'b1 && r0_ready_i) : (r1_valid_o === 1'b1 && r1_ready_i))
          obs_ret.push_back(winner == 0 ? r0_data_o : r1_data_o);
        if (winner == 0 ? (r0_valid_i && r0_ready_o === 1'b1) : (r1_valid_i && r1_ready_o === 1'b1))
          load_n++;
        if (collecting && srt_valid_o === 1'b1 && srt_ready_i) obs_load.push_back(srt_data_o);
        if (collecting && obs_load.size() == DEPTH) begin
          collecting = 0;
          srt_q = sorted_copy(obs_load);
        end
      end
    end
    timeout = !done;
    if (done) model_last_grant = (winner == 1);
    if (inj_cyc >= 0) model_err = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({busy_o, owner_o, err_o} !== 3'b000) begin
      errors++; $display("FAIL reset_status busy/owner/err got %b want 000", {busy_o, owner_o, err_o});
    end
    r0_valid_i = 1'b1; r1_valid_i = 1'b1; srt_valid_i = 1'b1; srt_ready_i = 1'b1;
    r0_ready_i = 1'b1; r1_ready_i = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if ({r0_ready_o, r1_ready_o, r0_valid_o, r1_valid_o, srt_valid_o, srt_ready_o} !== 6'b0) begin
      errors++; $display("FAIL reset_handshakes got %b want 000000",
                         {r0_ready_o, r1_ready_o, r0_valid_o, r1_valid_o, srt_valid_o, srt_ready_o});
    end
    checks++;
    if ({busy_o, err_o} !== 2'b00) begin
      errors++; $display("FAIL reset_hold busy/err got %b want 00", {busy_o, err_o});
    end
    clear_inputs();
    #1 reset_i = 1'b0;
    model_last_grant = 1'b1; model_err = 1'b0;
  endtask

  task automatic test_single();
    plan(1'b1, 1'b0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) in_q[i] = WIDTH'(DEPTH - 1 - i);
    do_batch();
    checks++; if (timeout) begin errors++; $display("FAIL single_timeout got 1 want 0"); end
    checks++; if (got_owner !== 1'b0) begin errors++; $display("FAIL single_owner got %b want 0", got_owner); end
    checks++;
    if (obs_load.size() != DEPTH || obs_ret.size() != DEPTH) begin
      errors++; $display("FAIL single_count got %0d/%0d want %0d", obs_load.size(), obs_ret.size(), DEPTH);
    end
    for (int i = 0; i < DEPTH && i < obs_load.size() && i < obs_ret.size(); i++) begin
      checks++;
      if (obs_load[i] !== WIDTH'(DEPTH - 1 - i) || obs_ret[i] !== WIDTH'(i)) begin
        errors++; $display("FAIL single_elem[%0d] got load %0d ret %0d want %0d %0d",
                           i, obs_load[i], obs_ret[i], DEPTH - 1 - i, i);
      end
    end
    checks++; if (nonowner_act) begin errors++; $display("FAIL single_r1_quiet got active want quiet"); end
    checks++; if (iso_viol) begin errors++; $display("FAIL single_isolation got leak want none"); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL single_busy_fall got %b want 0", busy_after); end
    checks++; if (err_o !== model_err) begin errors++; $display("FAIL single_err got %b want %b", err_o, model_err); end
    clear_inputs();
  endtask

  task automatic test_tie();
    @(posedge clk_i); #2 reset_i = 1'b1;
    #2 reset_i = 1'b0;
    model_last_grant = 1'b1; model_err = 1'b0;
    plan(1'b1, 1'b1, 20, 20, 20);
    do_batch();
    checks++; if (timeout) begin errors++; $display("FAIL tie_timeout got 1 want 0"); end
    checks++; if (got_owner !== 1'b0) begin errors++; $display("FAIL tie_first_owner got %b want 0", got_owner); end
    checks++; if (nonowner_act) begin errors++; $display("FAIL tie_r1_ready got active want 0"); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL tie_idle got busy %b want 0", busy_after); end
    @(posedge clk_i); #1;
    checks++;
    if ({busy_o, owner_o} !== 2'b11) begin
      errors++; $display("FAIL tie_next_grant busy/owner got %b want 11", {busy_o, owner_o});
    end
    plan(1'b0, 1'b1, 20, 20, 20);
    do_batch();
    checks++; if (timeout || got_owner !== 1'b1) begin
      errors++; $display("FAIL tie_second_owner got %b (timeout %0d) want 1", got_owner, timeout);
    end
    checks++; if (obs_ret.size() != DEPTH) begin errors++; $display("FAIL tie_second_count got %0d want %0d", obs_ret.size(), DEPTH); end
    for (int i = 0; i < obs_ret.size() && i < DEPTH; i++) begin
      checks++;
      if (obs_ret[i] !== exp_ret[i]) begin errors++; $display("FAIL tie_second_elem[%0d] got %0d want %0d", i, obs_ret[i], exp_ret[i]); end
    end
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [1:0] seen;
    plan(1'b1, 1'b0, 0, 0, 0);
    do_batch();
    seen[0] = got_owner;
    checks++; if (timeout || got_owner !== 1'b0) begin errors++; $display("FAIL rr_solo got %b want 0", got_owner); end
    plan(1'b1, 1'b1, 10, 10, 10);
    do_batch();
    seen[1] = got_owner;
    checks++; if (timeout || got_owner !== 1'(winner)) begin errors++; $display("FAIL rr_tie1 got %b want %0d", got_owner, winner); end
    checks++; if (obs_ret.size() != DEPTH || obs_ret[DEPTH-1] !== exp_ret[DEPTH-1]) begin
      errors++; $display("FAIL rr_tie1_data got %0d elems want %0d sorted", obs_ret.size(), DEPTH);
    end
    plan(1'b1, 1'b1, 10, 10, 10);
    do_batch();
    checks++; if (timeout || got_owner !== 1'(winner)) begin errors++; $display("FAIL rr_tie2 got %b want %0d", got_owner, winner); end
    checks++; if (seen !== 2'b10) begin errors++; $display("FAIL rr_sequence got %b want 10", seen); end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    plan(1'b1, 1'b0, 0, 0, 0);
    hold_at = 3; hold_len = 5;
    do_batch();
    checks++; if (timeout) begin errors++; $display("FAIL bp_timeout got 1 want 0"); end
    checks++; if (hold_viol) begin errors++; $display("FAIL bp_srt_ready got 1 during hold want 0"); end
    checks++; if (obs_ret.size() != DEPTH) begin errors++; $display("FAIL bp_count got %0d want %0d", obs_ret.size(), DEPTH); end
    for (int i = 0; i < obs_ret.size() && i < DEPTH; i++) begin
      checks++;
      if (obs_ret[i] !== exp_ret[i]) begin errors++; $display("FAIL bp_elem[%0d] got %0d want %0d", i, obs_ret[i], exp_ret[i]); end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_load();
    int n, cyc;
    n = 0; cyc = 0;
    clear_inputs();
    while (n < 4 && cyc < 200) begin
      @(posedge clk_i); #1; cyc++;
      r0_valid_i = 1'b1; r0_data_i = WIDTH'($urandom); srt_ready_i = 1'b1;
      #1;
      if (r0_ready_o === 1'b1) n++;
    end
    @(posedge clk_i); #1;
    checks++; if (n != 4 || busy_o !== 1'b1) begin errors++; $display("FAIL mid_setup got %0d loads busy %b want 4 1", n, busy_o); end
    #2 reset_i = 1'b1;
    #1;
    checks++;
    if ({busy_o, r0_ready_o, r1_ready_o, srt_valid_o, owner_o} !== 5'b0) begin
      errors++; $display("FAIL mid_async_reset busy/rdy0/rdy1/sv/owner got %b want 00000",
                         {busy_o, r0_ready_o, r1_ready_o, srt_valid_o, owner_o});
    end
    clear_inputs();
    #2 reset_i = 1'b0;
    model_last_grant = 1'b1; model_err = 1'b0;
    plan(1'b1, 1'b0, 0, 0, 0);
    do_batch();
    checks++; if (timeout || obs_load.size() != DEPTH) begin
      errors++; $display("FAIL mid_fresh_batch got %0d loads (timeout %0d) want %0d", obs_load.size(), timeout, DEPTH);
    end
    checks++; if (obs_ret.size() != DEPTH || obs_ret[0] !== exp_ret[0]) begin
      errors++; $display("FAIL mid_fresh_drain got %0d elems want %0d", obs_ret.size(), DEPTH);
    end
    clear_inputs();
  endtask

  task automatic test_error();
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL err_before got %b want 0", err_o); end
    plan(1'b1, 1'b0, 0, 0, 0);
    err_at = 5;
    do_batch();
    checks++; if (err_after_inject !== 1'b1) begin errors++; $display("FAIL err_next_edge got %b want 1", err_after_inject); end
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err_o); end
    checks++; if (timeout || obs_load.size() != DEPTH || obs_ret.size() != DEPTH) begin
      errors++; $display("FAIL err_flow got %0d/%0d want %0d", obs_load.size(), obs_ret.size(), DEPTH);
    end
    for (int i = 0; i < obs_ret.size() && i < DEPTH; i++) begin
      checks++;
      if (obs_ret[i] !== exp_ret[i]) begin errors++; $display("FAIL err_elem[%0d] got %0d want %0d", i, obs_ret[i], exp_ret[i]); end
    end
    clear_inputs();
  endtask

  task automatic test_random();
    int pick;
    for (int b = 0; b < 8; b++) begin
      pick = $urandom_range(2);
      plan(pick != 1, pick != 0, $urandom_range(50), $urandom_range(50), $urandom_range(50));
      do_batch();
      checks++; if (timeout) begin errors++; $display("FAIL rnd%0d_timeout got 1 want 0", b); end
      checks++; if (got_owner !== 1'(winner) || owner_changed) begin
        errors++; $display("FAIL rnd%0d_owner got %b (changed %0d) want %0d", b, got_owner, owner_changed, winner);
      end
      checks++; if (obs_load.size() != DEPTH || obs_ret.size() != DEPTH) begin
        errors++; $display("FAIL rnd%0d_count got %0d/%0d want %0d", b, obs_load.size(), obs_ret.size(), DEPTH);
      end
      for (int i = 0; i < DEPTH && i < obs_load.size() && i < obs_ret.size(); i++) begin
        checks++;
        if (obs_load[i] !== in_q[i] || obs_ret[i] !== exp_ret[i]) begin
          errors++; $display("FAIL rnd%0d_elem[%0d] got %0d/%0d want %0d/%0d",
                             b, i, obs_load[i], obs_ret[i], in_q[i], exp_ret[i]);
        end
      end
      checks++; if (nonowner_act || iso_viol) begin
        errors++; $display("FAIL rnd%0d_isolation got nonowner %0d leak %0d want 0 0", b, nonowner_act, iso_viol);
      end
      checks++; if (busy_after !== 1'b0 || err_o !== model_err) begin
        errors++; $display("FAIL rnd%0d_end busy/err got %b%b want 0%b", b, busy_after, err_o, model_err);
      end
      clear_inputs();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_round_robin();
    test_backpressure();
    test_reset_mid_load();
    test_error();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
